// File: rtl/serial_adder_n_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM encoding and width limit.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_n_if.sv
// Request/result bundle of the serial adder; master drives operands and start,
// slave (the adder) returns busy/done and the registered result.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, op_sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_n_fa.sv
// Single-bit full adder, purely combinational; the only arithmetic in the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit add/subtract, LSB first; done pulses WIDTH clocks after the accepting edge.
// start is ignored while busy; results update only on the final shift edge or reset.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_adder_n_if.slave bus
);
  import serial_adder_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder_n: WIDTH out of range 1..32");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             accept, last;
  logic             busy, done;

  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last   = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

  full_adder_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (last)      state_d = ST_DONE;
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // carry_q at the last edge is the carry into the MSB, hence the overflow term.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.op_sub ? ~bus.b : bus.b;
      carry_d = bus.op_sub | bus.cin;
      cnt_d   = '0;
    end else if (state_q == ST_SHIFT) begin
      a_sh_d            = a_sh_q >> 1;
      b_sh_d            = b_sh_q >> 1;
      r_sh_d            = r_sh_q >> 1;
      r_sh_d[WIDTH-1]   = fa_s;
      carry_d           = fa_c;
      cnt_d             = cnt_q + 1'b1;
      if (last) begin
        sum_d  = r_sh_d;
        cout_d = fa_c;
        ovf_d  = carry_q ^ fa_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Randomised and directed bench for serial_adder_n at WIDTH=8 and WIDTH=1,
// checked against an integer-arithmetic reference model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(8)) b8 ();
  serial_adder_n_if #(.WIDTH(1)) b1 ();

  serial_adder_n #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  serial_adder_n #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: unsigned sum for result/carry, true signed arithmetic for overflow.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic co, output logic ov);
    longint m   = (longint'(1) << w) - 1;
    longint ua  = longint'(a) & m;
    longint ub  = longint'(b) & m;
    longint ci  = longint'(cin);
    longint hi  = (longint'(1) << (w - 1));
    longint tot, sa, sb, res;
    tot = sub ? (ua + ((~ub) & m) + 1) : (ua + ub + ci);
    s   = 32'(tot & m);
    co  = ((tot >> w) & 1) != 0;
    sa  = (ua >= hi) ? ua - (m + 1) : ua;
    sb  = (ub >= hi) ? ub - (m + 1) : ub;
    res = sub ? (sa - sb) : (sa + sb + ci);
    ov  = (res < -hi) || (res > hi - 1);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, input bit repulse);
    logic [31:0] es;
    logic        eco, eov;
    logic [7:0]  prev;
    int          cyc = 0;
    int          nb = 0;
    bit          moved = 1'b0;
    model(8, 32'(a), 32'(b), cin, sub, es, eco, eov);
    prev = b8.sum;
    b8.a = a; b8.b = b; b8.cin = cin; b8.op_sub = sub; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.a = 8'($urandom); b8.b = 8'($urandom);
    b8.cin = 1'($urandom); b8.op_sub = 1'($urandom);
    while (!b8.done && cyc < 40) begin
      if (b8.busy) nb++;
      if (b8.sum !== prev) moved = 1'b1;
      if (repulse) begin
        b8.start = (cyc == 2);
        b8.a = 8'($urandom); b8.b = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    b8.start = 1'b0;
    chk("w8_latency", 32'(cyc), 32'd8);
    chk("w8_busy_cycles", 32'(nb), 32'd8);
    chk("w8_sum_held_midop", 32'(moved), 32'd0);
    chk("w8_busy_at_done", 32'(b8.busy), 32'd0);
    chk("w8_sum", 32'(b8.sum), es);
    chk("w8_cout", 32'(b8.cout), 32'(eco));
    chk("w8_ovf", 32'(b8.ovf), 32'(eov));
  endtask

  task automatic idle8();
    logic [7:0] s;
    s = b8.sum;
    @(posedge clk); #1;
    chk("w8_done_one_cycle", 32'(b8.done), 32'd0);
    chk("w8_idle_busy", 32'(b8.busy), 32'd0);
    chk("w8_sum_holds", 32'(b8.sum), 32'(s));
  endtask

  task automatic op1(input logic a, input logic b, input logic cin, input logic sub);
    logic [31:0] es;
    logic        eco, eov;
    int          cyc = 0;
    model(1, 32'(a), 32'(b), cin, sub, es, eco, eov);
    b1.a = a; b1.b = b; b1.cin = cin; b1.op_sub = sub; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    chk("w1_busy", 32'(b1.busy), 32'd1);
    while (!b1.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w1_latency", 32'(cyc), 32'd1);
    chk("w1_sum", 32'(b1.sum), es);
    chk("w1_cout", 32'(b1.cout), 32'(eco));
    chk("w1_ovf", 32'(b1.ovf), 32'(eov));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.op_sub = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0; b1.op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    chk("rst_sum", 32'(b8.sum), 32'd0);
    chk("rst_cout", 32'(b8.cout), 32'd0);
    chk("rst_ovf", 32'(b8.ovf), 32'd0);
    chk("rst_w1_sum", 32'(b1.sum), 32'd0);
    rst = 1'b0;

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0); idle8();
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); idle8();
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0); idle8();
    op8(8'h05, 8'h07, 1'b1, 1'b1, 1'b0); idle8();
    op8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0); idle8();

    // start re-pulsed mid-shift must not disturb the running operation
    op8(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1); idle8();

    // start held through DONE: the second operation is accepted in the DONE cycle
    op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    op8(8'hA0, 8'h0B, 1'b0, 1'b1, 1'b0); idle8();

    // reset in the fourth shift cycle aborts and clears the result
    b8.a = 8'h55; b8.b = 8'h66; b8.cin = 1'b0; b8.op_sub = 1'b0; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(b8.busy), 32'd0);
    chk("abort_done", 32'(b8.done), 32'd0);
    chk("abort_sum", 32'(b8.sum), 32'd0);
    chk("abort_cout", 32'(b8.cout), 32'd0);
    chk("abort_ovf", 32'(b8.ovf), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b8.done || b8.busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    for (int i = 0; i < 60; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) idle8();
    end
    idle8();

    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], 1'b0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      op1(i[1], i[0], 1'b1, 1'b1);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised successor to the single-bit full-adder board block.
- Adds or subtracts two WIDTH-bit operands bit-serially, LSB first, using one full-adder cell over WIDTH clock cycles.
- Uses a start/busy/done handshake and registers the result, including signed-overflow detection.
- Sits between switch/button inputs and LED outputs on the board top, and is reusable as a small-area arithmetic unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- op_sub  input  1  0 = a+b+cin; 1 = a-b (cin ignored).
- a  input  WIDTH  operand A; captured at accepted start.
- b  input  WIDTH  operand B; captured at accepted start.
- cin  input  1  carry-in for add mode; captured at accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when result registers update.
- sum  output  WIDTH  result; holds last completed value.
- cout  output  1  final carry-out; for subtract, 1 means no borrow.
- ovf  output  1  signed overflow, computed as carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and bit counter cleared.
- Reset has priority over every other input on any edge. Reset during SHIFT aborts the operation: no done pulse, and outputs are zeroed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge E0:
  - latch a into a_sh and b into b_sh (b_sh = ~b when op_sub=1);
  - carry = op_sub ? 1 : cin;
  - cnt = 0; go to SHIFT.
- DONE with start=0: go to IDLE. Back-to-back starts are therefore legal and lose no cycle.
- SHIFT, each edge:
  - full-adder cell on (a_sh[0], b_sh[0], carry) gives (s, c);
  - r_sh shifts right with s entering the MSB;
  - a_sh and b_sh shift right; carry = c; cnt += 1.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th SHIFT edge, EWIDTH):
    - load sum with the final r_sh value (including this bit);
    - cout = c;
    - ovf = carry_in_of_MSB ^ c;
    - go to DONE.
- busy=1 exactly in SHIFT (WIDTH cycles). done=1 exactly in DONE (one cycle, the cycle after EWIDTH).
- Latency: done is high in the cycle beginning at edge E(WIDTH), i.e. WIDTH clocks after the accepting edge.
- start while busy is ignored and not queued.
- a, b, cin and op_sub may change freely after the accepting edge.
- sum, cout and ovf change only on the final SHIFT edge or on reset, never mid-operation.
- WIDTH=1: one SHIFT cycle; ovf = cin_to_bit0 ^ cout.
- Counter width: $clog2(WIDTH)+1 bits; no wrap occurs inside a legal operation.

Decomposition:
- Package serial_adder_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - MAX_WIDTH=32 constant for the parameter range check.
- One sub-module, full_adder_cell: purely combinational, ports a, b, cin -> s, cout. It is instantiated once in the datapath.
- The board wrapper maps switches to a, b, cin and op_sub, a debounced button to start, and LEDs to sum, cout, ovf and busy. The wrapper is a separate file and is not part of this block.

Test Plan (WIDTH=8 unless noted):
- a=8'h0F, b=8'h01, cin=0, op_sub=0, start pulse -> busy high for 8 cycles; done one cycle later; sum=8'h10, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- op_sub=1, a=8'h05, b=8'h07, cin=1 (must be ignored) -> sum=8'hFE, cout=0, ovf=0. Then op_sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- start re-pulsed at cycle 3 of SHIFT with different operands -> ignored; first result delivered unchanged. Start held high through DONE -> second operation begins in the DONE cycle.
- rst asserted at cycle 4 of SHIFT -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows.
- WIDTH=1 build: a=1, b=1, cin=1 -> done 1 cycle after acceptance; sum=1, cout=1, ovf=0. Also sweep all 8 input combinations of (a, b, cin) against the truth table.
